mod_sub_serial: RTL and testbench
=================================

# mod_sub_serial

Word-serial 256-bit modular subtractor computing diff = (a − b) mod p, the inverse operation of the field adder in the elliptic-curve datapath. It processes one WORD-bit limb per clock with a ripple borrow, then conditionally adds p back in a second limb-serial pass. It sits beside the adder under the point-arithmetic sequencer, which issues operands and waits on a start/done handshake.

## Interface
- WIDTH, 256, operand and modulus width in bits
- WORD, 32, limb width processed per cycle; WIDTH must be a multiple of WORD
- Clk  in  1  clock; all state changes on the rising edge
- Reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- a  in  WIDTH  minuend; requires a < p
- b  in  WIDTH  subtrahend; requires b < p
- p  in  WIDTH  odd modulus
- busy  out  1  high while a request is in flight
- done  out  1  one-cycle pulse when diff becomes valid
- diff  out  WIDTH  result; held until the next accepted start

## Operation
- N = WIDTH/WORD limbs. States: IDLE, SUB, FIX, DONE.
- IDLE: when start = 1, latch a, b and p into internal registers, clear the borrow and limb counter, and go to SUB. Inputs are not sampled again until the next IDLE.
- SUB: each cycle, compute limb k of a − b − borrow. Write the result limb into the diff shift register, update the borrow, and increment k. After limb N−1:
  - final borrow = 1: go to FIX.
  - final borrow = 0: go to DONE.
- FIX: each cycle, add limb k of p to the diff limb with a ripple carry, for N cycles. The final carry out is discarded. Then go to DONE.
- DONE: assert done for exactly one cycle, then return to IDLE.
- Arithmetic is modulo 2^WIDTH within each pass. For in-range inputs the result is in [0, p−1]. For out-of-range inputs the result is whatever a single conditional add-back produces; no error is flagged.
- start while busy = 1 is ignored and never queued.
- start in the same cycle that done is high is ignored; a new request is accepted from IDLE on the following cycle.
- Reset (any time, including mid-operation): state goes to IDLE immediately.
  - busy = 0, done = 0, diff = 0.
  - Internal operand registers, borrow and counter are cleared.

## Timing
- Define cycle 0 as the rising edge that samples start in IDLE.
- busy is high from cycle 1 through the DONE cycle inclusive.
- No add-back: SUB occupies cycles 1..N, done is high in cycle N+1 (9 with defaults).
- Add-back: FIX occupies cycles N+1..2N, done is high in cycle 2N+1 (17 with defaults).
- diff is valid from the done cycle onward and stable until the next accepted start. Intermediate limbs are visible on diff during SUB and FIX; the consumer uses diff only on or after done.
- Reset values: busy = 0, done = 0, diff = 0.

## Configuration
- Macro MOD_SUB_CT_EN enables constant-time operation.
- Defined: FIX always runs. The addend is p when the final borrow is 1 and zero otherwise, so done is always at cycle 2N+1 and latency carries no data-dependent timing side channel.
- Undefined: FIX is skipped when there is no borrow, giving the data-dependent latency stated above.

## Structure
- Shared package ecc_pkg holds:
  - WIDTH and WORD defaults
  - the mod_sub_state_t enum (IDLE, SUB, FIX, DONE)
  - the P-256 prime constant P256 = 0xFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
- One sub-module, limb_addsub: combinational WORD-bit add/subtract with carry/borrow in and out, selected by an op input. It is shared by the SUB and FIX passes.
- The top level contains the FSM, the limb counter, the rotating operand and diff registers, and the single-bit borrow/carry register.

## Test plan
- a = 16, b = 6, p = P256 → diff = 10; done at cycle 9 (cycle 17 with MOD_SUB_CT_EN).
- a = 6, b = 16, p = P256 → diff = P256 − 10; done at cycle 17.
- a = b = 0x1234…ABCD (arbitrary value < P256) → diff = 0; no add-back; done at cycle 9.
- a = 0, b = P256 − 1 → diff = 1. Limb-boundary check: a = 0x1_00000000, b = 1 → diff = 0xFFFFFFFF.
- Pulse start at cycles 3 and 9 of a running request → both ignored; exactly one done; result matches the first request's operands.
- Assert Reset at cycle 5 of a request → busy, done and diff read 0 on the next edge. A fresh request after reset release completes correctly.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC field datapath.
// Holds default widths, the subtractor state enum and the P-256 prime.
package ecc_pkg;

    localparam int ECC_WIDTH = 256;
    localparam int ECC_WORD  = 32;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        FIX,
        DONE
    } mod_sub_state_t;

    localparam logic [255:0] P256 =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

endpackage

// File: rtl/mod_sub_serial_if.sv
// Request/response bundle between the point sequencer and mod_sub_serial.
// master = sequencer side, slave = subtractor side.
interface mod_sub_serial_if #(
    parameter int WIDTH = 256
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;

    modport master (
        output start, a, b, p,
        input  busy, done, diff
    );

    modport slave (
        input  start, a, b, p,
        output busy, done, diff
    );

endinterface

// File: rtl/limb_addsub.sv
// One-limb adder/subtractor with carry/borrow chaining.
// op = 1 subtracts (x - y - cin), op = 0 adds (x + y + cin).
module limb_addsub #(
    parameter int WORD = 32
) (
    input  logic [WORD-1:0] x,
    input  logic [WORD-1:0] y,
    input  logic            cin,
    input  logic            op,
    output logic [WORD-1:0] s,
    output logic            cout
);

    logic [WORD:0] r;

    // Extra top bit gives carry out on add, borrow (sign) on subtract.
    always_comb begin
        if (op) begin
            r = {1'b0, x} - {1'b0, y} - {{WORD{1'b0}}, cin};
        end else begin
            r = {1'b0, x} + {1'b0, y} + {{WORD{1'b0}}, cin};
        end
    end

    assign s    = r[WORD-1:0];
    assign cout = r[WORD];

endmodule

// File: rtl/mod_sub_serial.sv
// Word-serial modular subtractor: diff = (a - b) mod p, one limb per clock.
// Define MOD_SUB_CT_EN for constant-time operation (add-back pass always runs).
module mod_sub_serial
    import ecc_pkg::*;
#(
    parameter int WIDTH = ECC_WIDTH,
    parameter int WORD  = ECC_WORD
) (
    input logic            clk,
    input logic            rst,
    mod_sub_serial_if.slave bus
);

    localparam int N  = WIDTH / WORD;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    mod_sub_state_t state;
    mod_sub_state_t nxt;

    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rp;
    logic [WIDTH-1:0] rd;
    logic [CW-1:0]    cnt;
    logic             cy;
    logic             last;
    logic [WORD-1:0]  ax;
    logic [WORD-1:0]  ay;
    logic [WORD-1:0]  as;
    logic             aco;
    logic             aop;
`ifdef MOD_SUB_CT_EN
    logic             neg;
`endif

    assign last     = (cnt == CW'(N - 1));
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
    assign bus.diff = rd;

    // Limb operand select: a-b limbs in SUB, diff+p limbs in FIX.
    always_comb begin
        aop = 1'b1;
        ax  = ra[WORD-1:0];
        ay  = rb[WORD-1:0];
        if (state == FIX) begin
            aop = 1'b0;
            ax  = rd[WORD-1:0];
`ifdef MOD_SUB_CT_EN
            ay  = neg ? rp[WORD-1:0] : '0;
`else
            ay  = rp[WORD-1:0];
`endif
        end
    end

    limb_addsub #(
        .WORD (WORD)
    ) u_limb (
        .x    (ax),
        .y    (ay),
        .cin  (cy),
        .op   (aop),
        .s    (as),
        .cout (aco)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (bus.start) nxt = SUB;
            SUB: begin
                if (last) begin
`ifdef MOD_SUB_CT_EN
                    nxt = FIX;
`else
                    nxt = aco ? FIX : DONE;
`endif
                end
            end
            FIX:  if (last) nxt = DONE;
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Operand latch, limb shifting, counter and borrow/carry chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra  <= '0;
            rb  <= '0;
            rp  <= '0;
            rd  <= '0;
            cnt <= '0;
            cy  <= 1'b0;
`ifdef MOD_SUB_CT_EN
            neg <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra  <= bus.a;
                        rb  <= bus.b;
                        rp  <= bus.p;
                        cnt <= '0;
                        cy  <= 1'b0;
                    end
                end
                SUB: begin
                    rd  <= {as, rd[WIDTH-1:WORD]};
                    ra  <= ra >> WORD;
                    rb  <= rb >> WORD;
                    cnt <= last ? '0 : cnt + CW'(1);
                    cy  <= last ? 1'b0 : aco;
`ifdef MOD_SUB_CT_EN
                    if (last) neg <= aco;
`endif
                end
                FIX: begin
                    rd  <= {as, rd[WIDTH-1:WORD]};
                    rp  <= {rp[WORD-1:0], rp[WIDTH-1:WORD]};
                    cnt <= last ? '0 : cnt + CW'(1);
                    cy  <= last ? 1'b0 : aco;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_sub_serial.sv
// Self-checking bench for mod_sub_serial (scoreboard + immediate asserts).
// Honours MOD_SUB_CT_EN for the expected latency.
module tb_mod_sub_serial;
    import ecc_pkg::*;

    typedef struct {
        logic [255:0] d;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    mod_sub_serial_if #(.WIDTH(256)) bus ();

    mod_sub_serial #(
        .WIDTH (256),
        .WORD  (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, want);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 256'(bus.busy), 256'(0));
        chk({tag, "_done"}, 256'(bus.done), 256'(0));
        chk({tag, "_diff"}, bus.diff, 256'(0));
    endtask

    // inj1/inj2: cycles at which start is pulsed again; rst_at: reset cycle
    task automatic run(input logic [255:0] ta,
                       input logic [255:0] tb,
                       input string tag,
                       input int inj1,
                       input int inj2,
                       input int rst_at);
        logic [256:0] t;
        exp_t e;
        exp_t g;
        int ndone;
        int dcyc;
        t = {1'b0, ta} - {1'b0, tb};
        e.d = t[255:0] + (t[256] ? P256 : 256'(0));
`ifdef MOD_SUB_CT_EN
        e.cyc = 17;
`else
        e.cyc = t[256] ? 17 : 9;
`endif
        q.push_back(e);
        ndone = 0;
        dcyc = -1;
        @(negedge clk);
        bus.a = ta;
        bus.b = tb;
        bus.p = P256;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~ta;
        bus.b = ta;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus.start = (cyc == inj1) || (cyc == inj2);
            if (cyc == 1) chk({tag, "_busy1"}, 256'(bus.busy), 256'(1));
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                chk_zero({tag, "_rst"});
                @(posedge clk);
                #1;
                chk_zero({tag, "_rstedge"});
                rst = 1'b0;
                bus.start = 1'b0;
                void'(q.pop_front());
                return;
            end
            if (dcyc > 0 && cyc == dcyc + 1) begin
                chk({tag, "_idle"}, 256'(bus.busy), 256'(0));
            end
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    dcyc = cyc;
                    g = q.pop_front();
                    chk({tag, "_diff"}, bus.diff, g.d);
                    chk({tag, "_lat"}, 256'(cyc), 256'(g.cyc));
                end
            end
        end
        bus.start = 1'b0;
        chk({tag, "_ndone"}, 256'(ndone), 256'(1));
    endtask

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.p = P256;
        #2;
        chk_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_hold");
        rst = 1'b0;

        run(256'd16, 256'd6, "small", -1, -1, -1);
        run(256'd6, 256'd16, "wrap", -1, -1, -1);
        ra = 256'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321_1234_5678_9ABC_DEF0_0FED_CBA9_8765_ABCD;
        run(ra, ra, "equal", -1, -1, -1);
        run(256'd0, P256 - 256'd1, "zero_pm1", -1, -1, -1);
        run(256'h1_0000_0000, 256'd1, "limb", -1, -1, -1);
        run(256'd16, 256'd6, "overlap", 3, 9, -1);
        run(256'd6, 256'd16, "midrst", -1, -1, 5);
        run(P256 - 256'd1, P256 - 256'd2, "after_rst", -1, -1, -1);

        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 8; w++) begin
                ra[w*32 +: 32] = $urandom;
                rb[w*32 +: 32] = $urandom;
            end
            ra[255] = 1'b0;
            rb[255] = 1'b0;
            run(ra, rb, "rand", -1, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
